// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive types and constants
package uart_pkg;

  localparam int BYTE_W        = 8;
  localparam int DEFAULT_DEPTH = 16;

  typedef struct packed {
    logic              error;
    logic [BYTE_W-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with wrapping pointers and occupancy counter
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [LW-1:0]    level,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_rd   = rd_en && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive byte FIFO with pulse handshake, drop-on-full and error status
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int ERR_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     in_req,
  output logic                     in_ready,
  input  logic [BYTE_W-1:0]        in_data,
  input  logic                     in_error,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W-1:0]        out_data,
  output logic                     out_error,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [ERR_CNT_W-1:0]     err_count,
  input  logic                     clr_status
);

  rx_entry_t wr_entry;
  rx_entry_t rd_entry;
  logic      fifo_empty;
  logic      fifo_full;
  logic      handshake;
  logic      pop;
  logic      accept;
  logic      drop;
  logic      err_event;

  assign handshake = in_req && in_ready;
  assign pop       = out_valid && out_ready;
  assign accept    = handshake && (!fifo_full || pop);
  // Upstream always completes; a byte with nowhere to go is simply lost.
  assign drop      = handshake && !accept;
  assign err_event = accept && in_error;

  assign wr_entry.error = in_error;
  assign wr_entry.data  = in_data;
  assign out_valid      = !fifo_empty;
  assign out_data       = rd_entry.data;
  assign out_error      = rd_entry.error;

  sync_fifo #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_  (reset_),
    .wr_en   (accept),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (rd_entry),
    .level   (level),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      in_ready  <= 1'b0;
      overflow  <= 1'b0;
      err_count <= '0;
    end else begin
      in_ready <= in_req && !in_ready;

      if (drop)            overflow <= 1'b1;
      else if (clr_status) overflow <= 1'b0;

      // A same-cycle error byte outranks the clear, leaving a count of one.
      if (clr_status)
        err_count <= ERR_CNT_W'(err_event);
      else if (err_event && (err_count != '1))
        err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_ = 1'b0;
  logic          in_req = 1'b0;
  logic          in_ready;
  logic [7:0]    in_data = 8'h00;
  logic          in_error = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    out_data;
  logic          out_error;
  logic [LW-1:0] level;
  logic          overflow;
  logic [7:0]    err_count;
  logic          clr_status = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH), .ERR_CNT_W(8)) dut (
    .clk        (clk),
    .reset_     (reset_),
    .in_req     (in_req),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_error   (in_error),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_error  (out_error),
    .level      (level),
    .overflow   (overflow),
    .err_count  (err_count),
    .clr_status (clr_status)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Holds in_req until the accept pulse, then releases it after the handshake edge.
  task automatic send_byte(input logic [7:0] d, input logic e, input logic pop, input logic clr);
    int n;
    in_req   = 1'b1;
    in_data  = d;
    in_error = e;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!in_ready && n < 10);
    if (!in_ready) check("ready_timeout", 32'd0, 32'd1);
    out_ready  = pop;
    clr_status = clr;
    @(posedge clk); #1;
    in_req     = 1'b0;
    out_ready  = 1'b0;
    clr_status = 1'b0;
    check("ready_single_pulse", in_ready, 32'd0);
  endtask

  task automatic pop_check(input logic [7:0] d, input logic e);
    check("pop_valid", out_valid, 32'd1);
    check("pop_data", out_data, d);
    check("pop_error", out_error, e);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic clr_pulse();
    clr_status = 1'b1;
    @(posedge clk); #1;
    clr_status = 1'b0;
  endtask

  initial begin
    int n;
    #12;
    check("rst_level", level, 32'd0);
    check("rst_valid", out_valid, 32'd0);
    check("rst_ready", in_ready, 32'd0);
    check("rst_overflow", overflow, 32'd0);
    check("rst_err_count", err_count, 32'd0);
    @(posedge clk); #1;
    reset_ = 1'b1;
    @(posedge clk); #1;

    // single byte, latency one
    send_byte(8'h41, 1'b0, 1'b0, 1'b0);
    check("t1_valid", out_valid, 32'd1);
    check("t1_data", out_data, 32'h41);
    check("t1_level", level, 32'd1);
    pop_check(8'h41, 1'b0);
    check("t1_empty", out_valid, 32'd0);

    // fill then overflow
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0, 1'b0, 1'b0);
    check("t2_full_level", level, 32'd16);
    check("t2_no_ovf", overflow, 32'd0);
    send_byte(8'hAA, 1'b0, 1'b0, 1'b0);
    check("t2_level", level, 32'd16);
    check("t2_overflow", overflow, 32'd1);
    for (int i = 0; i < 16; i++) pop_check(8'(i), 1'b0);
    check("t2_drained", out_valid, 32'd0);
    check("t2_ovf_sticky", overflow, 32'd1);

    // full with a pop in the handshake cycle
    clr_pulse();
    check("t3_ovf_clr", overflow, 32'd0);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    send_byte(8'h55, 1'b0, 1'b1, 1'b0);
    check("t3_overflow", overflow, 32'd0);
    check("t3_level", level, 32'd16);
    for (int i = 1; i < 16; i++) pop_check(8'(8'h10 + i), 1'b0);
    pop_check(8'h55, 1'b0);
    check("t3_drained", level, 32'd0);

    // error bytes and status clear
    for (int i = 0; i < 3; i++) send_byte(8'(8'hE1 + i), 1'b1, 1'b0, 1'b0);
    check("t4_err_count", err_count, 32'd3);
    for (int i = 0; i < 3; i++) pop_check(8'(8'hE1 + i), 1'b1);
    clr_pulse();
    check("t4_err_clr", err_count, 32'd0);
    send_byte(8'h5A, 1'b1, 1'b0, 1'b1);
    check("t4_clr_vs_event", err_count, 32'd1);
    pop_check(8'h5A, 1'b1);

    // saturation
    for (int i = 0; i < 254; i++) send_byte(8'(i), 1'b1, 1'b1, 1'b0);
    check("t5_err_255", err_count, 32'd255);
    send_byte(8'hFE, 1'b1, 1'b1, 1'b0);
    check("t5_err_sat", err_count, 32'd255);
    check("t5_level", level, 32'd1);
    pop_check(8'hFE, 1'b1);

    // dropped error byte, then reset mid-handshake with level five
    clr_pulse();
    for (int i = 0; i < 16; i++) send_byte(8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    send_byte(8'hBB, 1'b1, 1'b0, 1'b0);
    check("t6_drop_no_err", err_count, 32'd0);
    check("t6_overflow", overflow, 32'd1);
    for (int i = 0; i < 11; i++) pop_check(8'(8'h80 + i), 1'b0);
    check("t6_level5", level, 32'd5);
    in_req  = 1'b1;
    in_data = 8'h77;
    in_error = 1'b0;
    @(posedge clk); #1;
    #2 reset_ = 1'b0;
    #1;
    check("t6_rst_level", level, 32'd0);
    check("t6_rst_valid", out_valid, 32'd0);
    check("t6_rst_overflow", overflow, 32'd0);
    check("t6_rst_ready", in_ready, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_ = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!in_ready && n < 10);
    check("t6_new_pulse", in_ready, 32'd1);
    @(posedge clk); #1;
    in_req = 1'b0;
    check("t6_level1", level, 32'd1);
    check("t6_data", out_data, 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entry count; power of two, 2..256.
REQ-002 SHALL have parameter ERR_CNT_W, default 8, error-counter width.
REQ-003 SHALL have port clk  input  1  clock; all logic is on the rising edge.
REQ-004 SHALL have port reset_  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_req  input  1  upstream byte-available flag; held high until in_ready is seen.
REQ-006 SHALL have port in_ready  output  1  one-cycle accept pulse to upstream.
REQ-007 SHALL have port in_data  input  8  upstream byte.
REQ-008 SHALL have port in_error  input  1  upstream stop-bit error flag for in_data.
REQ-009 SHALL have port out_valid  output  1  FIFO non-empty, head entry presented.
REQ-010 SHALL have port out_ready  input  1  downstream pop strobe.
REQ-011 SHALL have port out_data  output  8  head byte.
REQ-012 SHALL have port out_error  output  1  error flag stored with the head byte.
REQ-013 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 SHALL have port overflow  output  1  sticky flag: a byte was dropped.
REQ-015 SHALL have port err_count  output  ERR_CNT_W  saturating count of accepted bytes with in_error=1.
REQ-016 SHALL have port clr_status  input  1  synchronous clear of overflow and err_count.

Function
REQ-017 SHALL drive in_ready as a registered pulse: in_ready <= in_req && !in_ready; it is never high for two consecutive cycles.
REQ-018 SHALL take the handshake at cycle t when in_req=1 and in_ready=1, capturing {in_error, in_data} at that edge.
REQ-019 SHALL write the handshake into the FIFO if level<DEPTH, or if level==DEPTH and a pop occurs in the same cycle.
REQ-020 SHALL otherwise discard the byte, set overflow, and still complete the handshake, so upstream is never stalled.
REQ-021 SHALL present the head entry show-ahead: out_valid=(level!=0); out_data/out_error are valid whenever out_valid=1.
REQ-022 SHALL pop the head on a cycle with out_valid && out_ready; out_ready while empty has no effect.
REQ-023 SHALL make a written byte visible at out_valid on the cycle after the handshake (latency 1).
REQ-024 SHALL, on a simultaneous push and pop, leave level unchanged and keep the order intact.
REQ-025 SHALL use read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, with level held as a separate counter.
REQ-026 SHALL increment err_count on each written byte with in_error=1, saturating at all-ones.
REQ-027 SHALL not increment err_count for dropped bytes.
REQ-028 SHALL, on clr_status=1, zero overflow and err_count; an event in the same cycle wins (counter becomes 1, or overflow stays set).
REQ-029 SHALL have no FIFO flush other than reset.

Reset
REQ-030 SHALL, on reset_ low, asynchronously clear pointers, level, in_ready, overflow and err_count; out_valid=0.
REQ-031 SHALL not reset the storage array; out_data/out_error are don't-care while out_valid=0.
REQ-032 SHALL abandon any in-flight handshake on reset mid-operation; a still-high in_req after reset is handled as new.

Structure
REQ-033 SHALL take the shared package uart_pkg for: byte width constant (8), entry struct {error, data}, and the default DEPTH.
REQ-034 SHALL place storage and pointers in one sub-module, sync_fifo (parameterised width/depth, show-ahead); uart_rx_fifo adds the handshake, drop policy and status.

Verification
REQ-035 SHALL cover: in_req held high with in_data=0x41 -> exactly one in_ready pulse; next cycle out_valid=1, out_data=0x41, level=1.
REQ-036 SHALL cover: 16 bytes 0x00..0x0F with no pops, then 0xAA -> level=16, overflow=1, 0xAA dropped; pops return 0x00..0x0F in order.
REQ-037 SHALL cover: FIFO full with a pop in the handshake cycle of 0x55 -> 0x55 written, overflow=0, level stays 16.
REQ-038 SHALL cover: 3 bytes with in_error=1 -> err_count=3 and out_error=1 per entry; clr_status -> err_count=0.
REQ-039 SHALL cover: err_count at 255 plus one error byte -> stays 255.
REQ-040 SHALL cover: reset_ pulse with level=5 and in_req high -> level=0, out_valid=0, overflow=0, and a new in_ready pulse after release.
